// File: rtl/stage_sequencer.sv
// Multi-cycle LEGv8 phase sequencer: walks one instruction through fetch, decode,
// execute, optional memory and writeback, pulsing one registered strobe per phase.
module stage_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             uncond_branch,
    input  logic             branch,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             reg_read_en,
    output logic             alu_en,
    output logic             mem_req,
    output logic             reg_write_en,
    output logic             pc_write,
    output logic             pc_src,
    output logic             busy,
    output logic [2:0]       stage,
    output logic [CNT_W-1:0] instr_count,
    output logic             mem_error
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [7:0]       wait_reg, wait_next;
    logic             reg_write_reg, reg_write_next;
    logic             pc_src_next;
    logic             mem_error_next;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        state_next     = state_reg;
        wait_next      = wait_reg;
        reg_write_next = reg_write_reg;
        pc_src_next    = pc_src;
        mem_error_next = mem_error;
        count_next     = instr_count;
        case (state_reg)
            S_IDLE:    if (start) state_next = S_FETCH;
            S_FETCH:   state_next = S_DECODE;
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: begin
                pc_src_next    = uncond_branch | (branch & alu_zero);
                reg_write_next = reg_write;
                wait_next      = 8'd0;
                // A combined read+write still issues only one request.
                state_next     = (mem_read | mem_write) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    state_next = S_WRITEBACK;
                end else if (wait_reg == WAIT_LAST) begin
                    mem_error_next = 1'b1;
                    state_next     = S_HALT;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            S_WRITEBACK: begin
                if (instr_count != '1) count_next = instr_count + CNT_W'(1);
                state_next = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
    end

    // Strobes are registered from the next state so each is a clean flop output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            wait_reg      <= 8'd0;
            reg_write_reg <= 1'b0;
            pc_src        <= 1'b0;
            mem_error     <= 1'b0;
            instr_count   <= '0;
            ir_load       <= 1'b0;
            reg_read_en   <= 1'b0;
            alu_en        <= 1'b0;
            mem_req       <= 1'b0;
            reg_write_en  <= 1'b0;
            pc_write      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            reg_write_reg <= reg_write_next;
            pc_src        <= pc_src_next;
            mem_error     <= mem_error_next;
            instr_count   <= count_next;
            ir_load       <= (state_next == S_FETCH);
            reg_read_en   <= (state_next == S_DECODE);
            alu_en        <= (state_next == S_EXECUTE);
            mem_req       <= (state_next == S_MEMORY);
            reg_write_en  <= (state_next == S_WRITEBACK) & reg_write_next;
            pc_write      <= (state_next == S_WRITEBACK);
            busy          <= (state_next != S_IDLE) && (state_next != S_HALT);
        end
    end

    assign stage = state_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: expected per-cycle output vectors are queued
// with the stimulus and popped one per clock after each rising edge.
module tb_stage_sequencer;

    localparam int CW = 3;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, halt_req = 1'b0, uncond_branch = 1'b0, branch = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
    logic ir_load, reg_read_en, alu_en, mem_req, reg_write_en, pc_write, pc_src, busy, mem_error;
    logic [2:0]    stage;
    logic [CW-1:0] instr_count;

    typedef logic [3+7+1+CW+1-1:0] vec_t;
    vec_t sb[$];
    vec_t e;
    int vectors = 0;
    int miscompares = 0;

    stage_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .uncond_branch(uncond_branch), .branch(branch), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .ir_load(ir_load), .reg_read_en(reg_read_en),
        .alu_en(alu_en), .mem_req(mem_req), .reg_write_en(reg_write_en),
        .pc_write(pc_write), .pc_src(pc_src), .busy(busy), .stage(stage),
        .instr_count(instr_count), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    function automatic vec_t obs();
        return {stage, ir_load, reg_read_en, alu_en, mem_req, reg_write_en, pc_write,
                pc_src, busy, instr_count, mem_error};
    endfunction

    // strb = {ir_load, reg_read_en, alu_en, mem_req, reg_write_en, pc_write, pc_src}
    task automatic push(input logic [2:0] st, input logic [6:0] strb, input int cnt, input logic err);
        logic b;
        b = (st != 3'd0) && (st != 3'd6);
        sb.push_back({st, strb, b, CW'(cnt), err});
    endtask

    task automatic push_instr(input logic mr, input logic mw, input logic rw, input logic pn,
                              input logic po, input int waits, input int cnt);
        push(3'd1, {6'b100000, po}, cnt, 1'b0);
        push(3'd2, {6'b010000, po}, cnt, 1'b0);
        push(3'd3, {6'b001000, po}, cnt, 1'b0);
        if (mr | mw)
            for (int w = 0; w <= waits; w++) push(3'd4, {6'b000100, pn}, cnt, 1'b0);
        push(3'd5, {4'b0000, rw, 1'b1, pn}, cnt, 1'b0);
    endtask

    task automatic do_reset();
        {start, halt_req, uncond_branch, branch, mem_read, mem_write, reg_write, alu_zero, mem_ready} = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) push(3'd0, 7'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            halt_req = 1'b1; mem_ready = 1'b1;
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got %h required %h", i, obs(), e);
            end
        end
        $display("test_reset: %0d vectors so far", vectors);
    endtask

    task automatic test_add();
        int n;
        do_reset();
        push_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        push(3'd1, 7'b1000000, 1, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            start = (i == 0); reg_write = 1'b1; mem_ready = 1'b1;
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL add cycle %0d: got %h required %h", i, obs(), e);
            end
        end
        $display("test_add: ADD retired, count %0d", instr_count);
    endtask

    task automatic test_ldur();
        int n;
        do_reset();
        push_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        push(3'd1, 7'b1000000, 1, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            start = (i == 0); mem_read = 1'b1; reg_write = 1'b1; mem_ready = (i >= 7);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL ldur cycle %0d: got %h required %h", i, obs(), e);
            end
        end
        $display("test_ldur: LDUR with 3 wait cycles retired");
    endtask

    task automatic test_branch();
        int n, k;
        do_reset();
        push_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1);
        push_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2);
        push(3'd1, 7'b1000001, 3, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            k = i / 4;
            start = (i == 0); branch = (k < 2); uncond_branch = (k == 2); alu_zero = (k == 0);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL branch instr %0d cycle %0d: got %h required %h", k, i, obs(), e);
            end
        end
        $display("test_branch: CBZ taken, CBZ not taken, B retired back to back");
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        push(3'd1, 7'b1000000, 0, 1'b0);
        push(3'd2, 7'b0100000, 0, 1'b0);
        push(3'd3, 7'b0010000, 0, 1'b0);
        for (int w = 0; w < TO; w++) push(3'd4, 7'b0001000, 0, 1'b0);
        for (int h = 0; h < 3; h++) push(3'd6, 7'b0, 0, 1'b1);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            start = (i == 0) || (i >= 18); mem_write = 1'b1; reg_write = 1'b1; mem_ready = 1'b0;
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL timeout cycle %0d: got %h required %h", i, obs(), e);
            end
        end
        $display("test_timeout: STUR timed out, mem_error %0b", mem_error);
    endtask

    task automatic test_halt();
        int n;
        do_reset();
        for (int k = 0; k < 3; k++) push_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, k);
        for (int h = 0; h < 4; h++) push(3'd6, 7'b0, 3, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            start = (i == 0) || (i >= 12); halt_req = (i == 12); reg_write = 1'b1;
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL halt cycle %0d: got %h required %h", i, obs(), e);
            end
        end
        $display("test_halt: halted after %0d instructions", instr_count);
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        for (int k = 0; k < 9; k++) push_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, (k > 7) ? 7 : k);
        push(3'd1, 7'b1000000, 7, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            start = (i == 0);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL saturate cycle %0d: got %h required %h", i, obs(), e);
            end
        end
        $display("test_saturate: count held at %0d", instr_count);
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        push_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        push(3'd1, 7'b1000000, 1, 1'b0);
        push(3'd2, 7'b0100000, 1, 1'b0);
        push(3'd3, 7'b0010000, 1, 1'b0);
        push(3'd4, 7'b0001000, 1, 1'b0);
        push(3'd4, 7'b0001000, 1, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            start = (i == 0); reg_write = 1'b1; mem_read = (i >= 4); mem_ready = 1'b0;
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL reset_mid lead cycle %0d: got %h required %h", i, obs(), e);
            end
        end
        #2 reset = 1'b0;
        #1;
        push(3'd0, 7'b0, 0, 1'b0);
        e = sb.pop_front(); vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL reset_mid async clear: got %h required %h", obs(), e);
        end
        @(posedge clk); #1;
        push(3'd0, 7'b0, 0, 1'b0);
        e = sb.pop_front(); vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL reset_mid held: got %h required %h", obs(), e);
        end
        reset = 1'b1; mem_read = 1'b0; mem_ready = 1'b1;
        push(3'd0, 7'b0, 0, 1'b0);
        push_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        push(3'd1, 7'b1000000, 1, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            start = (i == 1);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL reset_mid restart cycle %0d: got %h required %h", i, obs(), e);
            end
        end
        $display("test_reset_mid: restarted, count %0d", instr_count);
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur();
        test_branch();
        test_timeout();
        test_halt();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control sequencer for the LEGv8 datapath. It replaces the free-running oscillator and fixed delay-chain phase clocks with one clock and a state machine. Each phase enable pulses for exactly one clock cycle, in order: fetch, register read, execute, memory, writeback. Control bits come from `iDecode`, and the ALU zero flag comes from the execute stage. The enables drive `fetch` (PC/IR load), the register-file read and write strobes, the ALU, and the data-memory request handshake.

## Interface
- `CNT_W`, 16: width of the retired-instruction counter.
- `MEM_TIMEOUT`, 15: maximum cycles spent waiting for `mem_ready` before declaring an error. Range 1 to 255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 immediately forces the reset state.
- `start`  in  1  level; begins execution when sampled high in IDLE.
- `halt_req`  in  1  level; sampled in WRITEBACK, stops after the current instruction.
- `uncond_branch`, `branch`, `mem_read`, `mem_write`, `reg_write`  in  1 each  decode control bits, valid from DECODE onward.
- `alu_zero`  in  1  ALU zero flag, valid during EXECUTE.
- `mem_ready`  in  1  data-memory completion, sampled while `mem_req` is high.
- `ir_load`  out  1  fetch-stage IR/PC+4 capture strobe.
- `reg_read_en`  out  1  register-file read strobe.
- `alu_en`  out  1  execute strobe.
- `mem_req`  out  1  data-memory request, held until accepted.
- `reg_write_en`  out  1  register-file write strobe.
- `pc_write`  out  1  PC update strobe.
- `pc_src`  out  1  branch-taken select for the PC mux.
- `busy`  out  1  high in every state except IDLE and HALT.
- `stage`  out  3  current state encoding.
- `instr_count`  out  CNT_W  count of retired instructions.
- `mem_error`  out  1  sticky memory-timeout flag.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Encoding 7 is illegal and goes to HALT with `mem_error` unchanged.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- IDLE: all strobes 0. If `start`=1, go to FETCH; otherwise stay in IDLE.
- FETCH: `ir_load`=1. Go to DECODE.
- DECODE: `reg_read_en`=1. Go to EXECUTE.
- EXECUTE: `alu_en`=1. On the exit edge, capture these into internal registers:
  - `pc_src` = `uncond_branch` | (`branch` & `alu_zero`)
  - `mem_read`, `mem_write`, `reg_write`
- EXECUTE next state: MEMORY if captured `mem_read`|`mem_write`, else WRITEBACK.
- MEMORY: `mem_req`=1 every cycle in this state.
  - If `mem_ready`=1, go to WRITEBACK.
  - A wait counter increments on each cycle with `mem_ready`=0. When it reaches `MEM_TIMEOUT`, set `mem_error`=1 and go to HALT with no writeback.
  - The wait counter clears on entry to MEMORY.
  - If both `mem_read` and `mem_write` were captured, treat the access as a single request.
- WRITEBACK: `pc_write`=1, and `reg_write_en` = captured `reg_write`.
  - `instr_count` increments and saturates at all-ones.
  - Go to HALT if `halt_req`=1, else to FETCH.
- HALT: all strobes 0, `busy`=0. Leave only via `reset`; `start` is ignored.
- `pc_src` holds its captured value from EXECUTE exit until the next EXECUTE exit, and is 0 after reset.

## Timing
- Reset values:
  - state = IDLE
  - every strobe, `pc_src`, `busy`, `mem_error` = 0
  - `instr_count` = 0
  - `stage` = 0
- Reset asserted mid-instruction: outputs clear asynchronously. No partial `pc_write` or `reg_write_en` pulse may follow. Operation resumes only when `start` is next seen in IDLE after reset is released.
- `start` sampled high at edge k puts FETCH in cycle k+1.
- Instruction latency:
  - no memory access: 4 cycles (F, D, E, WB)
  - memory access with zero wait: 5 cycles
  - each low cycle of `mem_ready` adds one cycle
- Every strobe except `mem_req` is high for exactly one cycle per instruction. At most one phase strobe is high in any cycle.
- `mem_ready` is ignored outside MEMORY.
- If `halt_req` and `start` are both high in WRITEBACK, halt wins.

## Test plan
- ADD, no memory: `start`=1 for one cycle, `reg_write`=1 → `ir_load`, `reg_read_en`, `alu_en`, then `pc_write`+`reg_write_en` in cycles 1–4; `instr_count`=1; `pc_src`=0; back to FETCH in cycle 5.
- LDUR, `mem_read`=1, `mem_ready` low for 3 cycles then high → `mem_req` high for 4 cycles, WRITEBACK in cycle 8, `reg_write_en`=1 once.
- CBZ taken, `branch`=1 and `alu_zero`=1 → `pc_src`=1 from cycle 4 onward, `reg_write_en`=0 in WRITEBACK. Repeat with `alu_zero`=0 → `pc_src`=0. Repeat with `uncond_branch`=1 → `pc_src`=1 regardless of `alu_zero`.
- STUR with `mem_ready` stuck at 0 and `MEM_TIMEOUT`=15 → after 15 wait cycles `mem_error`=1, state HALT, no `pc_write` pulse, `instr_count` unchanged.
- `halt_req`=1 during the 3rd WRITEBACK → `stage`=6 next cycle, `instr_count`=3, `busy`=0; `start` pulses have no effect.
- `reset`=0 asserted mid-MEMORY between clock edges → all outputs 0 immediately, `stage`=0. After release with `start`=1, a fresh FETCH begins and `instr_count` restarts from 0.
